obi_mem_responder: RTL and testbench
====================================

OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 Parameter DepthWords, default 4096: memory size in 32-bit words; power of 2.
REQ-002 Parameter MaxOutstanding, default 2: response FIFO depth; range 1..4.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 req_i  input  1  host request valid.
REQ-006 gnt_o  output  1  request accepted this cycle.
REQ-007 addr_i  input  32  byte address; bits [1:0] ignored.
REQ-008 we_i  input  1  1 = write, 0 = read.
REQ-009 be_i  input  4  byte enables for writes.
REQ-010 wdata_i  input  32  write data.
REQ-011 rvalid_o  output  1  response valid, one-cycle pulse per accepted request.
REQ-012 rdata_o  output  32  read data; 0 for writes and errored requests.
REQ-013 err_o  output  1  error flag, qualified by rvalid_o.
REQ-014 cfg_gnt_delay_i  input  4  cycles req_i must be high before gnt_o.
REQ-015 cfg_rvalid_delay_i  input  4  extra response latency in cycles.
REQ-016 cfg_err_base_i  input  32  error-window base address.
REQ-017 cfg_err_mask_i  input  32  error-window mask; all-zero mask disables the window.

Function
REQ-018 Grant FSM states: G_IDLE, G_WAIT; wait counter gcnt is 4 bits and saturates.
REQ-019 G_IDLE -> G_WAIT when req_i=1 and no grant occurs this cycle; G_WAIT -> G_IDLE on grant or when req_i=0; gcnt clears on either transition.
REQ-020 gnt_o = req_i AND (gcnt >= cfg_gnt_delay_i) AND (fifo_count < MaxOutstanding); combinational; cfg_gnt_delay_i=0 gives same-cycle grant.
REQ-021 Grant eligibility uses only the registered fifo_count; a pop in the same cycle does not free a slot for that cycle's grant.
REQ-022 Error condition: (mask != 0 AND (addr_i & mask) == (base & mask)), OR word address >= DepthWords.
REQ-023 Grant cycle, no error: write updates only the bytes enabled by be_i; read captures the memory word. Both use the pre-write value for the same-cycle read path.
REQ-024 Grant cycle, error: memory is not written; entry err=1, rdata=0.
REQ-025 Each grant pushes {rdata, err, delay = cfg_rvalid_delay_i sampled at grant} into the in-order FIFO.
REQ-026 Head latency counter starts the cycle after an entry becomes head. rvalid_o (registered) pulses when the counter reaches the entry's delay, and the entry pops the same cycle.
REQ-027 Into an empty FIFO, a grant in cycle T with delay D gives rvalid_o in cycle T+1+D. Consecutive responses are spaced at least 1+D_next cycles apart.
REQ-028 rdata_o and err_o hold their value while rvalid_o=0 and are driven to 0 with rvalid_o=0 only at reset.
REQ-029 A simultaneous push and pop leaves fifo_count unchanged; FIFO pointers wrap modulo MaxOutstanding.

Reset
REQ-030 On rst_i=1: gnt FSM to G_IDLE, gcnt=0, FIFO empty, head counter=0, rvalid_o=0, rdata_o=0, err_o=0. gnt_o is forced low during reset.
REQ-031 Reset mid-transaction discards all pending responses; no rvalid_o is issued for requests granted before reset.
REQ-032 Memory contents are not reset.

Structure
REQ-033 Shared package obi_mem_resp_pkg holds the grant-state enum and the response-entry struct {rdata 32, err 1, delay 4}.
REQ-034 The in-order FIFO is the single sub-module resp_fifo, parameterised by depth and entry type. The memory array stays inline.

Verification
REQ-035 gnt delay 0, rvalid delay 0; write 0xDEADBEEF, be=0xF, addr 0x100 at T; read 0x100 at T+2 -> gnt same cycle, rvalid at T+1 and T+3, second rdata=0xDEADBEEF, err=0.
REQ-036 Memory 0x11223344 at 0x40; write be=0x2, wdata 0x0000AA00; read back -> 0x1122AA44.
REQ-037 cfg_gnt_delay=3, req held from T -> gnt_o first high at T+3; req dropped at T+1 and re-raised -> count restarts.
REQ-038 MaxOutstanding=2, rvalid delay 5, three back-to-back requests -> third gnt withheld until the cycle after the first rvalid; responses arrive in order.
REQ-039 err base 0x20000, mask 0xFFFFFC00; write then read 0x20004 -> both err=1, rdata=0, memory unchanged; address 0x4000 with DepthWords=4096 -> err=1.
REQ-040 Two requests granted, rst_i pulsed before any rvalid -> no rvalid_o after reset, gnt_o low during reset, next request is serviced normally.

Source files
------------

// File: rtl/obi_mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : obi_mem_resp_pkg
// Purpose : Shared types for the OBI memory responder: grant FSM states and
//           the queued response entry.
// Revision: 1.0
// ============================================================================
package obi_mem_resp_pkg;

    localparam int unsigned GCNT_W = 4;

    typedef enum logic [0:0] {
        G_IDLE = 1'b0,
        G_WAIT = 1'b1
    } gnt_state_e;

    typedef struct packed {
        logic [31:0]       rdata;
        logic              err;
        logic [GCNT_W-1:0] delay;
    } resp_entry_t;

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : resp_fifo
// Purpose : In-order response FIFO with lookahead of next-cycle head/count so
//           the consumer can register its outputs without an extra cycle.
// Revision: 1.0
// ============================================================================
module resp_fifo
    import obi_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = resp_entry_t,
    parameter int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_next_o,
    output entry_t        head_next_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Nothing left behind the popped head: the incoming entry is next.
        if (count_q == CW'(pop_i)) begin
            head_next_o = push_data_i;
        end else begin
            head_next_o = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule
`default_nettype wire

// File: rtl/obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : obi_mem_responder
// Purpose : OBI memory responder with programmable grant/response latency,
//           address error window and an in-order outstanding-response queue.
// Revision: 1.0
// ============================================================================
module obi_mem_responder
    import obi_mem_resp_pkg::*;
#(
    parameter int unsigned DepthWords     = 4096,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic [3:0]  cfg_gnt_delay_i,
    input  logic [3:0]  cfg_rvalid_delay_i,
    input  logic [31:0] cfg_err_base_i,
    input  logic [31:0] cfg_err_mask_i
);

    localparam int unsigned AW = $clog2(DepthWords);
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);

    logic [31:0]       mem_q [DepthWords];

    gnt_state_e        gstate_q, gstate_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [GCNT_W:0]   gwait;

    logic [AW-1:0]     widx;
    logic              oob;
    logic              win_hit;
    logic              req_err;
    logic              unused_addr_lsb;

    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     fifo_count_next;
    resp_entry_t       push_entry;
    resp_entry_t       head_next;
    logic              pop;

    logic [GCNT_W-1:0] hcnt_q, hcnt_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    // ------------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------------
    assign widx            = addr_i[AW+1:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    generate
        if (AW >= 30) begin : g_full_range
            assign oob = 1'b0;
        end else begin : g_range_check
            assign oob = |addr_i[31:AW+2];
        end
    endgenerate

    assign win_hit = (cfg_err_mask_i != '0) &&
                     ((addr_i & cfg_err_mask_i) == (cfg_err_base_i & cfg_err_mask_i));
    assign req_err = win_hit || oob;

    // ------------------------------------------------------------------
    // Grant FSM. gcnt counts WAIT cycles after the first, so gwait is the
    // number of earlier consecutive cycles req_i has been held high.
    // ------------------------------------------------------------------
    assign gwait = {1'b0, gcnt_q} + {{GCNT_W{1'b0}}, (gstate_q == G_WAIT)};
    assign gnt_o = !rst_i && req_i &&
                   (gwait >= {1'b0, cfg_gnt_delay_i}) &&
                   (fifo_count < CW'(MaxOutstanding));

    always_comb begin
        gstate_d = gstate_q;
        gcnt_d   = gcnt_q;
        case (gstate_q)
            G_IDLE: begin
                if (req_i && !gnt_o) begin
                    gstate_d = G_WAIT;
                    gcnt_d   = '0;
                end
            end
            G_WAIT: begin
                if (gnt_o || !req_i) begin
                    gstate_d = G_IDLE;
                    gcnt_d   = '0;
                end else if (gcnt_q != '1) begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
            end
            default: begin
                gstate_d = G_IDLE;
                gcnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gstate_q <= G_IDLE;
            gcnt_q   <= '0;
        end else begin
            gstate_q <= gstate_d;
            gcnt_q   <= gcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory array (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[widx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        push_entry.rdata = (!we_i && !req_err) ? mem_q[widx] : 32'h0;
        push_entry.err   = req_err;
        push_entry.delay = cfg_rvalid_delay_i;
    end

    resp_fifo #(
        .DEPTH   (MaxOutstanding),
        .entry_t (resp_entry_t),
        .CW      (CW)
    ) u_resp_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (gnt_o),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .head_next_o  (head_next)
    );

    // ------------------------------------------------------------------
    // Response path. rvalid is decided one cycle ahead from the FIFO's
    // next-state so the outputs come straight from flops; the head pops
    // in the cycle its pulse is visible.
    // ------------------------------------------------------------------
    assign pop = rvalid_q;

    always_comb begin
        hcnt_d   = (pop || (fifo_count == '0)) ? '0 : hcnt_q + GCNT_W'(1);
        rvalid_d = (fifo_count_next != '0) && (hcnt_d == head_next.delay);
        rdata_d  = rvalid_d ? head_next.rdata : rdata_q;
        err_d    = rvalid_d ? head_next.err   : err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_obi_mem_responder
// Purpose : Directed self-checking bench for obi_mem_responder.
// Revision: 1.0
// ============================================================================
module tb_obi_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  cfg_gnt_delay;
    logic [3:0]  cfg_rvalid_delay;
    logic [31:0] cfg_err_base;
    logic [31:0] cfg_err_mask;

    int n_tests = 0;
    int n_fail  = 0;

    obi_mem_responder #(
        .DepthWords     (4096),
        .MaxOutstanding (2)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_i              (req),
        .gnt_o              (gnt),
        .addr_i             (addr),
        .we_i               (we),
        .be_i               (be),
        .wdata_i            (wdata),
        .rvalid_o           (rvalid),
        .rdata_o            (rdata),
        .err_o              (err),
        .cfg_gnt_delay_i    (cfg_gnt_delay),
        .cfg_rvalid_delay_i (cfg_rvalid_delay),
        .cfg_err_base_i     (cfg_err_base),
        .cfg_err_mask_i     (cfg_err_mask)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request with zero grant and response delay: grant same cycle,
    // response the following cycle.
    task automatic single(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #2;
        chk({tag, "_gnt"}, gnt, 1);
        cyc();
        req = 1'b0;
        #2;
        chk({tag, "_rvalid"}, rvalid, 1);
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_err"}, err, exp_err);
        cyc();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
        cfg_gnt_delay = 4'd0; cfg_rvalid_delay = 4'd0;
        cfg_err_base = '0; cfg_err_mask = '0;

        // Reset state
        cyc();
        req = 1'b1;
        #2;
        chk("rst_gnt", gnt, 0);
        cyc();
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        rst = 1'b0; req = 1'b0;
        cyc();

        // Write then read back at 0x100
        single(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, "w100");
        single(1'b0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, "r100");
        #2;
        chk("hold_rvalid", rvalid, 0);
        chk("hold_rdata", rdata, 32'hDEADBEEF);
        cyc();

        // Byte enables
        single(1'b1, 32'h40, 4'hF, 32'h11223344, 32'h0, 1'b0, "w40");
        single(1'b1, 32'h40, 4'h2, 32'h0000AA00, 32'h0, 1'b0, "w40_be2");
        single(1'b0, 32'h40, 4'h0, 32'h0, 32'h1122AA44, 1'b0, "r40");
        single(1'b1, 32'h44, 4'hF, 32'h55667788, 32'h0, 1'b0, "w44");
        single(1'b1, 32'h44, 4'h9, 32'hAB0000CD, 32'h0, 1'b0, "w44_be9");
        single(1'b0, 32'h44, 4'h0, 32'h0, 32'hAB6677CD, 1'b0, "r44");

        // Grant delay 3, request held
        cfg_gnt_delay = 4'd3;
        req = 1'b1; we = 1'b0; addr = 32'h40;
        for (int c = 0; c < 4; c++) begin
            #2;
            chk($sformatf("gd_held_c%0d", c), gnt, (c == 3));
            cyc();
        end
        req = 1'b0;
        #2;
        chk("gd_held_rvalid", rvalid, 1);
        chk("gd_held_rdata", rdata, 32'h1122AA44);
        cyc();

        // Grant delay 3, request dropped after one cycle and re-raised
        for (int c = 0; c < 6; c++) begin
            req = (c != 1);
            #2;
            chk($sformatf("gd_restart_c%0d", c), gnt, (c == 5));
            cyc();
        end
        req = 1'b0;
        #2;
        chk("gd_restart_rvalid", rvalid, 1);
        cyc();
        cfg_gnt_delay = 4'd0;

        // Outstanding limit with response delay 5; delay is sampled at grant
        cfg_rvalid_delay = 4'd5;
        for (int c = 0; c < 20; c++) begin
            req  = (c <= 7);
            we   = 1'b0;
            addr = (c == 0) ? 32'h100 : ((c == 1) ? 32'h40 : 32'h44);
            if (c == 8) cfg_rvalid_delay = 4'd0;
            #2;
            chk($sformatf("oo_gnt_c%0d", c), gnt, (c == 0 || c == 1 || c == 7));
            chk($sformatf("oo_rvalid_c%0d", c), rvalid, (c == 6 || c == 12 || c == 18));
            if (c == 6)  chk("oo_rdata_1", rdata, 32'hDEADBEEF);
            if (c == 12) chk("oo_rdata_2", rdata, 32'h1122AA44);
            if (c == 18) chk("oo_rdata_3", rdata, 32'hAB6677CD);
            cyc();
        end
        req = 1'b0;

        // Error window and address range
        single(1'b1, 32'h804, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, "w804");
        cfg_err_base = 32'h0002_0000; cfg_err_mask = 32'hFFFF_FC00;
        single(1'b1, 32'h20004, 4'hF, 32'h12345678, 32'h0, 1'b1, "w20004_err");
        single(1'b0, 32'h20004, 4'h0, 32'h0, 32'h0, 1'b1, "r20004_err");
        cfg_err_base = 32'h0000_0800;
        single(1'b1, 32'h804, 4'hF, 32'h0BADBEEF, 32'h0, 1'b1, "w804_win");
        single(1'b0, 32'h804, 4'h0, 32'h0, 32'h0, 1'b1, "r804_win");
        single(1'b0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, "r100_outside");
        cfg_err_mask = 32'h0;
        single(1'b0, 32'h804, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, "r804_unchanged");
        single(1'b0, 32'h4000, 4'h0, 32'h0, 32'h0, 1'b1, "r4000_oob");
        single(1'b0, 32'h102, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, "r102_lsb");

        // Reset with two responses pending
        cfg_rvalid_delay = 4'd5;
        req = 1'b1; we = 1'b0; addr = 32'h100;
        #2;
        chk("rr_gnt0", gnt, 1);
        cyc();
        addr = 32'h40;
        #2;
        chk("rr_gnt1", gnt, 1);
        cyc();
        rst = 1'b1;
        #2;
        chk("rr_gnt_in_rst0", gnt, 0);
        cyc();
        #2;
        chk("rr_gnt_in_rst1", gnt, 0);
        chk("rr_rvalid_in_rst", rvalid, 0);
        cyc();
        rst = 1'b0; req = 1'b0;
        #2;
        chk("rr_rdata_cleared", rdata, 0);
        cyc();
        for (int c = 0; c < 12; c++) begin
            #2;
            chk($sformatf("rr_no_rvalid_c%0d", c), rvalid, 0);
            cyc();
        end
        cfg_rvalid_delay = 4'd0;
        single(1'b0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, "rr_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
